// File: rtl/resp_checker.sv
`default_nettype none
// ============================================================================
//  Module   : resp_checker
//  Brief    : Loads a table of masked expected vectors, then compares one
//             strobed observation per table entry and reports error count,
//             first failing index and an overall pass flag.
//  Revision : 1.0 - initial release
// ============================================================================
module resp_checker #(
  parameter int DEPTH = 18,
  parameter int W     = 5
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         LD,
  input  logic [W-1:0] LD_DATA,
  input  logic [W-1:0] LD_MASK,
  input  logic         START,
  input  logic         STB,
  input  logic [W-1:0] OBS,
  output logic         BUSY,
  output logic         DONE,
  output logic         PASS,
  output logic [4:0]   IDX,
  output logic [4:0]   ERR_CNT,
  output logic [4:0]   FIRST_ERR,
  output logic [4:0]   LD_CNT
);

  // Table depth and index limits expressed at counter width
  localparam logic [4:0] c_DEPTH = 5'(DEPTH);
  localparam logic [4:0] c_LAST  = 5'(DEPTH - 1);
  localparam logic [4:0] c_NONE  = 5'd31;
  localparam logic [4:0] c_SAT   = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [4:0]     r_idx;
  logic [4:0]     r_err_cnt;
  logic [4:0]     r_first_err;
  logic [4:0]     r_ld_cnt;
  logic           r_busy;
  logic           r_done;
  logic           r_pass;

  // Each entry is stored as {mask, data}
  logic [2*W-1:0] r_tab [0:DEPTH-1];

  logic           w_idle_like;
  logic           w_full;
  logic           w_start_ok;
  logic           w_ld_we;
  logic [W-1:0]   w_exp_data;
  logic [W-1:0]   w_exp_mask;
  logic           w_mismatch;
  logic           w_cmp;
  logic [4:0]     w_err_nxt;
  logic [4:0]     w_first_nxt;

  // Load/start qualification and the per-strobe compare result
  always_comb begin
    w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
    w_full      = (r_ld_cnt == c_DEPTH);
    // START only takes effect once the whole table is loaded; it also
    // suppresses a simultaneous LD so a full table is never overwritten.
    w_start_ok  = w_idle_like && START && w_full;
    w_ld_we     = !RST && w_idle_like && LD && !w_full && !w_start_ok;

    w_exp_mask  = r_tab[r_idx][2*W-1:W];
    w_exp_data  = r_tab[r_idx][W-1:0];
    w_mismatch  = |((OBS ^ w_exp_data) & w_exp_mask);
    w_cmp       = (r_state == S_RUN) && STB;

    w_err_nxt   = r_err_cnt;
    w_first_nxt = r_first_err;
    if (w_cmp && w_mismatch) begin
      if (r_err_cnt != c_SAT) begin
        w_err_nxt = r_err_cnt + 5'd1;
      end
      if (r_first_err == c_NONE) begin
        w_first_nxt = r_idx;
      end
    end
  end

  // Table storage; no reset because LD_CNT alone decides validity
  always_ff @(posedge CLK) begin
    if (w_ld_we) begin
      r_tab[r_ld_cnt] <= {LD_MASK, LD_DATA};
    end
  end

  // Control state machine with registered status outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_idx       <= 5'd0;
      r_err_cnt   <= 5'd0;
      r_first_err <= c_NONE;
      r_ld_cnt    <= 5'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            r_state     <= S_RUN;
            r_idx       <= 5'd0;
            r_err_cnt   <= 5'd0;
            r_first_err <= c_NONE;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
          end else if (w_ld_we) begin
            r_ld_cnt    <= r_ld_cnt + 5'd1;
          end
        end
        S_RUN: begin
          if (w_cmp) begin
            r_err_cnt   <= w_err_nxt;
            r_first_err <= w_first_nxt;
            if (r_idx == c_LAST) begin
              r_state <= S_DONE;
              r_idx   <= 5'd0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_nxt == 5'd0);
            end else begin
              r_idx   <= r_idx + 5'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign PASS      = r_pass;
  assign IDX       = r_idx;
  assign ERR_CNT   = r_err_cnt;
  assign FIRST_ERR = r_first_err;
  assign LD_CNT    = r_ld_cnt;

endmodule
`default_nettype wire

// File: tb/tb_resp_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_resp_checker
//  Brief    : Scoreboard bench for resp_checker (DEPTH=18 and DEPTH=31).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_resp_checker;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Main instance, DEPTH=18
  logic       a_rst, a_ld, a_start, a_stb;
  logic [4:0] a_ld_data, a_ld_mask, a_obs;
  logic       a_busy, a_done, a_pass;
  logic [4:0] a_idx, a_err, a_first, a_ldcnt;

  // Saturation instance, DEPTH=31
  logic       b_rst, b_ld, b_start, b_stb;
  logic [4:0] b_ld_data, b_ld_mask, b_obs;
  logic       b_busy, b_done, b_pass;
  logic [4:0] b_idx, b_err, b_first, b_ldcnt;

  resp_checker #(.DEPTH(18), .W(5)) u_dut (
    .CLK(CLK), .RST(a_rst), .LD(a_ld), .LD_DATA(a_ld_data), .LD_MASK(a_ld_mask),
    .START(a_start), .STB(a_stb), .OBS(a_obs), .BUSY(a_busy), .DONE(a_done),
    .PASS(a_pass), .IDX(a_idx), .ERR_CNT(a_err), .FIRST_ERR(a_first), .LD_CNT(a_ldcnt)
  );

  resp_checker #(.DEPTH(31), .W(5)) u_sat (
    .CLK(CLK), .RST(b_rst), .LD(b_ld), .LD_DATA(b_ld_data), .LD_MASK(b_ld_mask),
    .START(b_start), .STB(b_stb), .OBS(b_obs), .BUSY(b_busy), .DONE(b_done),
    .PASS(b_pass), .IDX(b_idx), .ERR_CNT(b_err), .FIRST_ERR(b_first), .LD_CNT(b_ldcnt)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference model of the DEPTH=18 instance
  localparam int MD = 18;
  logic [4:0] m_data [0:31];
  logic [4:0] m_mask [0:31];
  int  m_ldcnt, m_idx, m_err, m_first;
  bit  m_run, m_done, m_pass;

  typedef struct {
    string      tag;
    logic [4:0] err, first, idx;
    logic       busy, done, pass;
  } exp_t;
  exp_t sb[$];

  task automatic model_reset();
    m_ldcnt = 0; m_idx = 0; m_err = 0; m_first = 31;
    m_run = 0; m_done = 0; m_pass = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".busy"},  a_busy,  m_run);
    check({tag, ".done"},  a_done,  m_done);
    check({tag, ".pass"},  a_pass,  m_pass);
    check({tag, ".idx"},   a_idx,   m_idx);
    check({tag, ".err"},   a_err,   m_err);
    check({tag, ".first"}, a_first, m_first);
    check({tag, ".ldcnt"}, a_ldcnt, m_ldcnt);
  endtask

  task automatic do_reset();
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    model_reset();
  endtask

  task automatic load(input logic [4:0] d, input logic [4:0] m);
    a_ld = 1'b1; a_ld_data = d; a_ld_mask = m;
    if (!m_run && m_ldcnt < MD) begin
      m_data[m_ldcnt] = d; m_mask[m_ldcnt] = m; m_ldcnt++;
    end
    tick();
    a_ld = 1'b0;
  endtask

  task automatic start_run();
    a_start = 1'b1;
    if (!m_run && m_ldcnt == MD) begin
      m_run = 1; m_idx = 0; m_err = 0; m_first = 31; m_done = 0; m_pass = 0;
    end
    tick();
    a_start = 1'b0;
  endtask

  // Drive one strobe, push the model's expectation, compare after the edge
  task automatic strobe(input logic [4:0] obs, input string tag);
    exp_t e;
    a_stb = 1'b1; a_obs = obs;
    if (m_run) begin
      if (((obs ^ m_data[m_idx]) & m_mask[m_idx]) != 5'd0) begin
        if (m_err < 31) m_err++;
        if (m_first == 31) m_first = m_idx;
      end
      if (m_idx == MD - 1) begin
        m_idx = 0; m_run = 0; m_done = 1; m_pass = (m_err == 0);
      end else begin
        m_idx++;
      end
    end
    e.tag = tag; e.err = 5'(m_err); e.first = 5'(m_first); e.idx = 5'(m_idx);
    e.busy = m_run; e.done = m_done; e.pass = m_pass;
    sb.push_back(e);
    tick();
    a_stb = 1'b0;
    e = sb.pop_front();
    check({e.tag, ".err"},   a_err,   e.err);
    check({e.tag, ".first"}, a_first, e.first);
    check({e.tag, ".idx"},   a_idx,   e.idx);
    check({e.tag, ".busy"},  a_busy,  e.busy);
    check({e.tag, ".done"},  a_done,  e.done);
    check({e.tag, ".pass"},  a_pass,  e.pass);
  endtask

  initial begin
    a_rst = 0; a_ld = 0; a_start = 0; a_stb = 0; a_ld_data = 0; a_ld_mask = 0; a_obs = 0;
    b_rst = 0; b_ld = 0; b_start = 0; b_stb = 0; b_ld_data = 0; b_ld_mask = 0; b_obs = 0;
    model_reset();

    // Reset values (both instances)
    b_rst = 1'b1;
    do_reset();
    b_rst = 1'b0;
    check_all("reset");
    check("sat_reset.first", b_first, 31);

    // Guards: START with 17 entries is ignored, 19th LD is dropped
    for (int i = 0; i < 17; i++) load(5'(i), 5'h1F);
    check("ld17.ldcnt", a_ldcnt, 17);
    start_run();
    check("start_short.busy", a_busy, 0);
    load(5'd17, 5'h1F);
    load(5'd9, 5'h1F);
    check("ld19.ldcnt", a_ldcnt, 18);
    strobe(5'd0, "stb_idle");

    // Happy path
    start_run();
    check_all("run0");
    for (int i = 0; i < 18; i++) strobe(5'(i), "happy");
    check("happy.pass", a_pass, 1);
    check("happy.first", a_first, 31);
    strobe(5'd7, "stb_done");

    // Errors at 3 and 10, rerun from DONE without reload
    start_run();
    for (int i = 0; i < 18; i++) begin
      strobe((i == 3 || i == 10) ? 5'(i) ^ 5'h10 : 5'(i), "err");
      if (i == 3) check("err3.err", a_err, 1);
      if (i == 6) begin
        start_run();
        check("start_in_run.idx", a_idx, 7);
      end
    end
    check("err.cnt", a_err, 2);
    check("err.first", a_first, 3);
    check("err.pass", a_pass, 0);

    // Re-run after the failing run
    start_run();
    for (int i = 0; i < 18; i++) strobe(5'(i), "rerun");
    check("rerun.pass", a_pass, 1);
    check("rerun.err", a_err, 0);

    // Reset mid-run
    start_run();
    for (int i = 0; i < 7; i++) strobe(5'(i), "prerst");
    do_reset();
    check_all("midrst");
    start_run();
    check("rst_start.busy", a_busy, 0);

    // Mask: entry 5 only checks the low two bits
    for (int i = 0; i < 18; i++) load(5'(i), (i == 5) ? 5'b00011 : 5'h1F);
    start_run();
    for (int i = 0; i < 18; i++) strobe((i == 5) ? 5'd5 ^ 5'b11100 : 5'(i), "mask");
    check("mask.err", a_err, 0);
    check("mask.pass", a_pass, 1);

    // Saturation on the DEPTH=31 instance: every strobe mismatches
    for (int i = 0; i < 31; i++) begin
      b_ld = 1'b1; b_ld_data = 5'd0; b_ld_mask = 5'h1F;
      tick();
    end
    b_ld = 1'b0;
    check("sat.ldcnt", b_ldcnt, 31);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check("sat.busy", b_busy, 1);
    for (int i = 0; i < 31; i++) begin
      b_stb = 1'b1; b_obs = 5'h1F;
      tick();
      if (i == 29) check("sat30.err", b_err, 30);
    end
    b_stb = 1'b0;
    check("sat.err", b_err, 31);
    check("sat.first", b_first, 0);
    check("sat.done", b_done, 1);
    check("sat.pass", b_pass, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
